unified_buffer_banked: RTL
==========================

// Module: unified_buffer_banked
// PURPOSE
//  Parametrised, banked successor of the TPU unified buffer: activation/weight storage between host and systolic array.
//  Three request ports with valid/ready handshakes:
//   - master: host DMA, byte-enable write plus read.
//   - r0: read feed to the matrix unit.
//   - w1: write-back from the activation unit.
//  Address-interleaved banks let r0 and w1 proceed in the same cycle. Read latency is configurable and freezes with enable.
// PARAMETERS
//  MATRIX_WIDTH  14    bytes per word (lanes)
//  BYTE_WIDTH    8     bits per lane
//  DEPTH         4096  total words; multiple of NUM_BANKS
//  NUM_BANKS     4     power of two, >=1; bank = addr % NUM_BANKS, row = addr / NUM_BANKS
//  READ_LATENCY  2     enabled cycles from read accept to rdata_valid; >=1
//  ADDR_WIDTH    24    request address width
// PORTS
//  clk            in   1                        clock
//  rst            in   1                        synchronous, active-high reset
//  enable         in   1                        pipeline advance; low = no accepts, read pipeline frozen
//  m_req_valid    in   1                        master request
//  m_req_ready    out  1                        master accepted when valid&ready
//  m_addr         in   ADDR_WIDTH               master word address
//  m_byte_we      in   MATRIX_WIDTH             per-lane write enable; all zero = pure read
//  m_wdata        in   MATRIX_WIDTH*BYTE_WIDTH  master write data, lane i at [i*BYTE_WIDTH +: BYTE_WIDTH]
//  m_rdata_valid  out  1                        master read data valid
//  m_rdata        out  MATRIX_WIDTH*BYTE_WIDTH  master read data
//  r0_req_valid   in   1                        read request, port 0
//  r0_req_ready   out  1                        port 0 accepted
//  r0_addr        in   ADDR_WIDTH               port 0 address
//  r0_rdata_valid out  1                        port 0 data valid
//  r0_rdata       out  MATRIX_WIDTH*BYTE_WIDTH  port 0 read data
//  w1_req_valid   in   1                        full-word write request, port 1
//  w1_req_ready   out  1                        port 1 accepted
//  w1_addr        in   ADDR_WIDTH               port 1 address
//  w1_wdata       in   MATRIX_WIDTH*BYTE_WIDTH  port 1 write data
//  err_oob        out  1                        sticky: an accepted request had addr >= DEPTH
// BEHAVIOUR
//  Reset:
//   - All outputs 0: readies, rdata_valid, rdata, err_oob.
//   - Read pipelines flushed; in-flight reads dropped, never delivered.
//   - Round-robin pointer set to favour w1.
//   - RAM contents are not reset and are preserved across rst.
//  Ready rules:
//   - Readies are combinational from valids, enable and the arbitration state.
//   - All readies are 0 while rst=1 or enable=0.
//  Arbitration, evaluated every enabled cycle:
//   - m_req_valid=1: master granted; r0_req_ready = w1_req_ready = 0.
//   - Otherwise r0 and w1 are both granted when their banks differ.
//   - Same bank (including same address): one grant only, by round-robin pointer; the pointer flips to the loser after the cycle.
//   - The pointer moves only on a same-bank conflict.
//   - A non-granted requester keeps valid high and address/data stable (standard valid/ready).
//  Master access:
//   - Lanes with m_byte_we[i]=1 are written; other lanes are untouched.
//   - A read result is returned for every master accept, including writes.
//   - Ordering is read-before-write: returned data is the word before this access's write.
//  Read timing:
//   - A read accepted in enabled cycle T gives rdata_valid=1 with data at enabled cycle T+READ_LATENCY, for one enabled cycle.
//   - enable=0 cycles are not counted; rdata/rdata_valid hold their value while enable=0.
//   - Back-to-back accepts give back-to-back data, 1 word/cycle/port.
//  Same-address ordering:
//   - A write accepted in cycle T is visible to any read accepted in cycle >= T+1.
//  Out-of-range (addr >= DEPTH):
//   - Request accepted normally; no RAM write.
//   - Read returns all-zero data with valid at normal latency.
//   - err_oob=1 from the next cycle until rst.
//  rst concurrent with valid: no accept, no write.
// TESTING
//  1. Reset, then m write addr 5, we=all 1, data 0x0102..0E. Next cycle r0 read addr 5 -> r0_rdata_valid exactly 2 cycles after accept, data 0x0102..0E.
//  2. Master partial write to addr 9, m_byte_we=14'h0001, lane0=0xAA, over word 0x11..11 -> returned read 0x11..11; later r0 read addr 9 -> lane0 0xAA, lanes 1-13 0x11.
//  3. r0 addr 4 and w1 addr 7 valid together (banks 0/3, NUM_BANKS=4) -> both ready the same cycle.
//     r0 addr 8 and w1 addr 12 (both bank 0) -> w1 first, r0 next cycle; then repeat -> r0 first (pointer alternates).
//  4. r0 reads at addr 0,1,2,3 back-to-back with enable low for 3 cycles mid-stream -> 4 valid words in order; latency = 2 enabled cycles; data held while enable low.
//  5. w1 write to addr 4096 (DEPTH=4096) -> accepted, RAM unchanged, err_oob=1 next cycle and stays set; r0 read of addr 5000 -> valid with all-zero data.
//  6. rst asserted with 2 r0 reads in flight -> no r0_rdata_valid pulse afterwards; a word written before rst reads back unchanged after rst.

Source files
------------

// File: rtl/unified_buffer_banked.sv
// unified_buffer_banked: banked activation/weight store with host, matrix-read and write-back ports
module unified_buffer_banked #(
    parameter int MATRIX_WIDTH = 14,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int NUM_BANKS = 4,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               m_req_valid,
    output logic                               m_req_ready,
    input  logic [ADDR_WIDTH-1:0]              m_addr,
    input  logic [MATRIX_WIDTH-1:0]            m_byte_we,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] m_wdata,
    output logic                               m_rdata_valid,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] m_rdata,
    input  logic                               r0_req_valid,
    output logic                               r0_req_ready,
    input  logic [ADDR_WIDTH-1:0]              r0_addr,
    output logic                               r0_rdata_valid,
    output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] r0_rdata,
    input  logic                               w1_req_valid,
    output logic                               w1_req_ready,
    input  logic [ADDR_WIDTH-1:0]              w1_addr,
    input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] w1_wdata,
    output logic                               err_oob
);
    localparam int W = MATRIX_WIDTH * BYTE_WIDTH;
    localparam int ROWS = DEPTH / NUM_BANKS;
    localparam int BKW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int L = READ_LATENCY;

    function automatic logic [BKW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return BKW'(a % ADDR_WIDTH'(NUM_BANKS));
    endfunction

    function automatic logic [RW-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        return RW'(a / ADDR_WIDTH'(NUM_BANKS));
    endfunction

    logic [W-1:0] mem [NUM_BANKS][ROWS];
    logic go, conflict, fav_w1;
    logic m_oob, r0_oob, w1_oob;
    logic [W-1:0] m_mask, m_rd, r0_rd;
    logic [L-1:0] m_vp, r0_vp;
    logic [W-1:0] m_dp [L];
    logic [W-1:0] r0_dp [L];

    assign go = !rst && enable;
    assign m_oob = m_addr >= ADDR_WIDTH'(DEPTH);
    assign r0_oob = r0_addr >= ADDR_WIDTH'(DEPTH);
    assign w1_oob = w1_addr >= ADDR_WIDTH'(DEPTH);
    assign conflict = r0_req_valid && w1_req_valid && bank_of(r0_addr) == bank_of(w1_addr);
    // fav_w1 picks the winner of a same-bank clash and flips to the loser afterwards
    assign m_req_ready = go && m_req_valid;
    assign r0_req_ready = go && !m_req_valid && r0_req_valid && (!conflict || !fav_w1);
    assign w1_req_ready = go && !m_req_valid && w1_req_valid && (!conflict || fav_w1);

    genvar i;
    for (i = 0; i < MATRIX_WIDTH; i++) begin : g_mask
        assign m_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{m_byte_we[i]}};
    end

    assign m_rd = m_oob ? '0 : mem[bank_of(m_addr)][row_of(m_addr)];
    assign r0_rd = r0_oob ? '0 : mem[bank_of(r0_addr)][row_of(r0_addr)];

    // master reads the old word in the same cycle it merges its byte lanes
    always_ff @(posedge clk)
        if (m_req_ready && !m_oob)
            mem[bank_of(m_addr)][row_of(m_addr)] <= (m_rd & ~m_mask) | (m_wdata & m_mask);
        else if (w1_req_ready && !w1_oob)
            mem[bank_of(w1_addr)][row_of(w1_addr)] <= w1_wdata;

    always_ff @(posedge clk)
        if (rst) begin
            m_vp <= '0;
            r0_vp <= '0;
            err_oob <= 1'b0;
            fav_w1 <= 1'b1;
            for (int k = 0; k < L; k++) begin
                m_dp[k] <= '0;
                r0_dp[k] <= '0;
            end
        end else if (enable) begin
            for (int k = L - 1; k > 0; k--) begin
                m_vp[k] <= m_vp[k-1];
                r0_vp[k] <= r0_vp[k-1];
                m_dp[k] <= m_dp[k-1];
                r0_dp[k] <= r0_dp[k-1];
            end
            m_vp[0] <= m_req_ready;
            r0_vp[0] <= r0_req_ready;
            m_dp[0] <= m_req_ready ? m_rd : '0;
            r0_dp[0] <= r0_req_ready ? r0_rd : '0;
            err_oob <= err_oob || (m_req_ready && m_oob) || (r0_req_ready && r0_oob)
                || (w1_req_ready && w1_oob);
            if (!m_req_valid && conflict) fav_w1 <= !fav_w1;
        end

    assign m_rdata_valid = m_vp[L-1];
    assign m_rdata = m_dp[L-1];
    assign r0_rdata_valid = r0_vp[L-1];
    assign r0_rdata = r0_dp[L-1];
endmodule
